// File: rtl/fetch_buffer.sv
// ============================================================================
// Module      : fetch_buffer
// Description : IF-stage prefetch FIFO of {pc, instr} pairs with valid/ready
//               handshake toward ID and a synchronous flush for taken branches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buffer #(
  parameter int N     = 32,
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [N-1:0]                 pc_in,
  input  logic [W-1:0]                 instr_in,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [N-1:0]                 out_pc,
  output logic [W-1:0]                 out_instr,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [N+W-1:0]       r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_CNT_W-1:0]   r_count;

  logic                 w_push;
  logic                 w_pop;
  logic [N+W-1:0]       w_head;

  // Handshake flags come only from the count register, so no input can
  // reach in_ready or out_valid combinationally.
  assign in_ready  = (r_count != c_FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_head    = r_mem[r_rd_ptr];

  assign out_pc    = out_valid ? w_head[N+W-1:W] : '0;
  assign out_instr = out_valid ? w_head[W-1:0]   : '0;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
    end
  end

  // Storage is deliberately left uncleared on reset/flush; the pointers and
  // count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && !flush && w_push)
      r_mem[r_wr_ptr] <= {pc_in, instr_in};
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffer.sv
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Directed self-checking bench for fetch_buffer (DEPTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_buffer #(.N(32), .W(32), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .pc_in     (pc_in),
    .instr_in  (instr_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; pc_in = '0; instr_in = '0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3];
    logic [31:0] ins [3];
    pcs[0] = 32'h00; pcs[1] = 32'h04; pcs[2] = 32'h08;
    ins[0] = 32'hA0; ins[1] = 32'hA1; ins[2] = 32'hA2;
    out_ready = 1'b1;
    in_valid = 1'b1; pc_in = pcs[0]; instr_in = ins[0];
    // no bypass: nothing is visible in the push cycle
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_no_bypass: out_valid %b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      pc_in = pcs[i]; instr_in = ins[i];
      step();
      n_checks++; if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_instr !== ins[i]) begin
        n_fail++; $display("FAIL stream_entry%0d: got v=%b pc=%h in=%h want v=1 pc=%h in=%h",
                           i, out_valid, out_pc, out_instr, pcs[i], ins[i]);
      end
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count%0d: got %0d want 1", i, count); end
    end
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL stream_drain: got v=%b cnt=%0d want v=0 cnt=0", out_valid, count);
    end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pc_in = 32'h100 + 32'(i * 4); instr_in = 32'hB0 + 32'(i);
      step();
    end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    n_checks++; if (out_pc !== 32'h100 || out_instr !== 32'hB0) begin
      n_fail++; $display("FAIL full_head: got pc=%h in=%h want pc=100 in=b0", out_pc, out_instr);
    end
    // pop and push together while full: ready must not rise in the same cycle
    out_ready = 1'b1; pc_in = 32'h118; instr_in = 32'hB6;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_comb_ready: got %b want 0", in_ready); end
    step();
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || count !== 3'd3) begin
      n_fail++; $display("FAIL full_after_pop: got rdy=%b cnt=%0d want rdy=1 cnt=3", in_ready, count);
    end
    for (int i = 1; i < 4; i++) begin
      n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(i * 4) || out_instr !== 32'hB0 + 32'(i)) begin
        n_fail++; $display("FAIL full_order%0d: got v=%b pc=%h in=%h want v=1 pc=%h in=%h",
                           i, out_valid, out_pc, out_instr, 32'h100 + 32'(i * 4), 32'hB0 + 32'(i));
      end
      step();
    end
    n_checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL full_drain: got v=%b cnt=%0d want v=0 cnt=0", out_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pc_in = 32'h200 + 32'(i * 4); instr_in = 32'hC0DE_0200 + 32'(i * 4);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pc_in = 32'h208 + 32'(i * 4); instr_in = 32'hC0DE_0208 + 32'(i * 4);
      step();
      want = 32'h204 + 32'(i * 4);
      n_checks++; if (count !== 3'd2 || out_pc !== want || out_instr !== (32'hC0DE_0000 | want)) begin
        n_fail++; $display("FAIL b2b_cycle%0d: got cnt=%0d pc=%h in=%h want cnt=2 pc=%h in=%h",
                           i, count, out_pc, out_instr, want, 32'hC0DE_0000 | want);
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++; if (count !== 3'd1 || out_pc !== 32'h224 || out_instr !== 32'hC0DE_0224) begin
      n_fail++; $display("FAIL b2b_tail: got cnt=%0d pc=%h in=%h want cnt=1 pc=224 in=c0de0224", count, out_pc, out_instr);
    end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'h300 + 32'(i * 4); instr_in = 32'hD0 + 32'(i);
      step();
    end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_prefill: got %0d want 3", count); end
    flush = 1'b1; pc_in = 32'h40; instr_in = 32'hDEAD; out_ready = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_state: got cnt=%0d v=%b pc=%h rdy=%b want cnt=0 v=0 pc=0 rdy=1",
                         count, out_valid, out_pc, in_ready);
    end
    out_ready = 1'b0; in_valid = 1'b1; pc_in = 32'h80; instr_in = 32'h80A;
    step();
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd1 || out_pc !== 32'h80 || out_instr !== 32'h80A) begin
      n_fail++; $display("FAIL flush_refetch: got cnt=%0d pc=%h in=%h want cnt=1 pc=80 in=80a", count, out_pc, out_instr);
    end
    out_ready = 1'b1;
    step();
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_alone: got cnt=%0d v=%b want cnt=0 v=0", count, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_in = 32'h400 + 32'(i * 4); instr_in = 32'hE0 + 32'(i);
      step();
    end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL rst_prefill: got %0d want 4", count); end
    in_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_state: got cnt=%0d v=%b pc=%h in=%h rdy=%b want 0 0 0 0 1",
                         count, out_valid, out_pc, out_instr, in_ready);
    end
    in_valid = 1'b1; pc_in = 32'h500; instr_in = 32'hF0;
    step();
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd1 || out_pc !== 32'h500 || out_instr !== 32'hF0) begin
      n_fail++; $display("FAIL rst_mid_push: got cnt=%0d pc=%h in=%h want cnt=1 pc=500 in=f0", count, out_pc, out_instr);
    end
    out_ready = 1'b1;
    step();
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_pop: got cnt=%0d v=%b want cnt=0 v=0", count, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
